// File: rtl/jtag_scan_sequencer.sv
// Master-side JTAG scan engine: runs single-word IR/DR scans on one target TAP
// with a divided TCK and returns the captured TDO bits right-aligned.
module jtag_scan_sequencer #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_IR,
  input  logic [5:0]         CMD_LEN,
  input  logic [MAX_LEN-1:0] CMD_DATA,
  output logic               RSP_VALID,
  output logic [MAX_LEN-1:0] RSP_DATA,
  output logic               RSP_ERR,
  output logic               TGT_TCK,
  output logic               TGT_TMS,
  output logic               TGT_TDI,
  output logic               TGT_TRSTB,
  input  logic               TGT_TDO
);

  localparam int unsigned DivW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int unsigned BitW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV);
  localparam logic [6:0] MaxLen7 = 7'(MAX_LEN);

  typedef enum logic [2:0] {
    StTapRst,
    StIdle,
    StHdr,
    StShift,
    StTrl,
    StResp
  } state_e;

  state_e               state_q;
  logic [DivW-1:0]      div_q;
  logic [2:0]           slot_q;
  logic [BitW-1:0]      bit_q;
  logic                 ir_q;
  logic [5:0]           len_q;
  logic [MAX_LEN-1:0]   data_q;
  logic [MAX_LEN-1:0]   cap_q;
  logic                 err_q;

  logic                 half_done;
  logic                 rise;
  logic                 slot_end;
  logic                 tck_active;
  logic                 last_bit;
  logic                 len_bad;
  logic [2:0]           hdr_last;
  logic [BitW-1:0]      bit_nxt;
  logic [5:0]           len_m1;

  always_comb begin
    half_done  = 1'b0;
    rise       = 1'b0;
    slot_end   = 1'b0;
    tck_active = 1'b0;
    last_bit   = 1'b0;
    len_bad    = 1'b0;
    hdr_last   = 3'd2;
    bit_nxt    = '0;
    len_m1     = '0;

    tck_active = (state_q == StTapRst) || (state_q == StHdr) ||
                 (state_q == StShift)  || (state_q == StTrl);
    half_done  = (div_q == DivLast);
    // A half-period ending with TCK low is the rising edge; with TCK high it closes the slot.
    rise       = tck_active && half_done && !TGT_TCK;
    slot_end   = tck_active && half_done && TGT_TCK;
    len_m1     = len_q - 6'd1;
    bit_nxt    = bit_q + BitW'(1);
    last_bit   = (6'(bit_q) == len_m1);
    hdr_last   = ir_q ? 3'd3 : 3'd2;
    len_bad    = (CMD_LEN == 6'd0) || ({1'b0, CMD_LEN} > MaxLen7);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StTapRst;
      div_q     <= '0;
      slot_q    <= '0;
      bit_q     <= '0;
      ir_q      <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      err_q     <= 1'b0;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      TGT_TCK   <= 1'b0;
      TGT_TMS   <= 1'b1;
      TGT_TDI   <= 1'b0;
      TGT_TRSTB <= 1'b0;
    end else begin
      TGT_TRSTB <= 1'b1;
      RSP_VALID <= 1'b0;

      if (tck_active) begin
        if (half_done) begin
          div_q   <= '0;
          TGT_TCK <= ~TGT_TCK;
        end else begin
          div_q <= div_q + DivW'(1);
        end
      end

      unique case (state_q)
        // Reset state doubles as the start of slot 0: five TMS=1 slots, then one TMS=0.
        StTapRst: begin
          if (slot_end) begin
            if (slot_q == 3'd5) begin
              state_q   <= StIdle;
              slot_q    <= '0;
              TGT_TMS   <= 1'b0;
              CMD_READY <= 1'b1;
            end else begin
              slot_q  <= slot_q + 3'd1;
              TGT_TMS <= (slot_q < 3'd4);
            end
          end
        end

        StIdle: begin
          TGT_TMS <= 1'b0;
          if (CMD_VALID && CMD_READY) begin
            CMD_READY <= 1'b0;
            ir_q      <= CMD_IR;
            len_q     <= CMD_LEN;
            data_q    <= CMD_DATA;
            cap_q     <= '0;
            slot_q    <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            if (len_bad) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              err_q   <= 1'b0;
              state_q <= StHdr;
              TGT_TMS <= 1'b1;
            end
          end else begin
            CMD_READY <= 1'b1;
          end
        end

        // DR header 1,0,0; IR header 1,1,0,0.
        StHdr: begin
          if (slot_end) begin
            if (slot_q == hdr_last) begin
              state_q <= StShift;
              slot_q  <= '0;
              bit_q   <= '0;
              TGT_TMS <= (len_q == 6'd1);
              TGT_TDI <= data_q[0];
            end else begin
              slot_q  <= slot_q + 3'd1;
              TGT_TMS <= ir_q && (slot_q == 3'd0);
            end
          end
        end

        StShift: begin
          if (rise) begin
            cap_q[bit_q] <= TGT_TDO;
          end
          if (slot_end) begin
            if (last_bit) begin
              state_q <= StTrl;
              slot_q  <= '0;
              TGT_TMS <= 1'b1;
              TGT_TDI <= 1'b0;
            end else begin
              bit_q   <= bit_nxt;
              TGT_TMS <= (6'(bit_nxt) == len_m1);
              TGT_TDI <= data_q[bit_nxt];
            end
          end
        end

        // Trailer: Exit1 -> Update (slot 0, TMS=1), Update -> Run-Test/Idle (slot 1, TMS=0).
        StTrl: begin
          if (slot_end) begin
            TGT_TMS <= 1'b0;
            if (slot_q == 3'd1) begin
              state_q <= StResp;
              slot_q  <= '0;
            end else begin
              slot_q <= 3'd1;
            end
          end
        end

        StResp: begin
          RSP_VALID <= 1'b1;
          RSP_ERR   <= err_q;
          RSP_DATA  <= err_q ? '0 : cap_q;
          state_q   <= StIdle;
        end

        default: begin
          state_q <= StTapRst;
        end
      endcase
    end
  end

endmodule
